// File: rtl/repetition_pkg.sv
// Shared definitions for the repetition detector and its stimulus generator.
//   gen_state_t : generator FSM states
//   LFSR_TAPS   : Galois feedback mask, x^32 + x^22 + x^2 + x + 1 (maximal length)
//   field_t     : header-field value at the default field width
package repetition_pkg;

  localparam int unsigned FIELD_SIZE_DEFAULT = 16;

  typedef logic [FIELD_SIZE_DEFAULT-1:0] field_t;

  localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FIRST,
    ST_RUN,
    ST_DONE
  } gen_state_t;

endpackage

// File: rtl/repetition_gen_lfsr_step.sv
// One step of a right-shifting Galois LFSR. This block is purely combinational.
//   current  : present LFSR state
//   taps     : feedback mask, XORed in when the bit shifted out is 1
//   advanced : state after one shift
module lfsr_step #(
  parameter int unsigned W = 32
) (
  input  logic [W-1:0] current,
  input  logic [W-1:0] taps,
  output logic [W-1:0] advanced
);

  always_comb begin
    advanced = {1'b0, current[W-1:1]};
    if (current[0]) begin
      advanced = advanced ^ taps;
    end
  end

endmodule

// File: rtl/repetition_gen.sv
// Stimulus generator: emits a window of field values on a valid/ready
// handshake with an exact number of back-to-back repetitions.
// Values that are not repeats come from an LFSR, so a given seed always
// produces the same sequence.
//   sys_clk, reset       : clock; asynchronous active-high reset
//   start                : starts a window (honoured only when idle)
//   cfg_len/nreps/seed   : window config, latched on an accepted start
//   ready                : downstream accepts the beat when valid && ready
//   valid, field, clear  : beat stream; clear marks the first beat of a window
//   busy, done           : window in progress; one-cycle end-of-window pulse
//   sent                 : beats accepted in the current or most recent window
module repetition_gen
  import repetition_pkg::*;
#(
  parameter int unsigned FIELD_SIZE = 16,
  parameter int unsigned LFSR_W     = 32
) (
  input  logic                  sys_clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [FIELD_SIZE-1:0] cfg_len,
  input  logic [FIELD_SIZE-1:0] cfg_nreps,
  input  logic [LFSR_W-1:0]     cfg_seed,
  input  logic                  ready,
  output logic                  valid,
  output logic [FIELD_SIZE-1:0] field,
  output logic                  clear,
  output logic                  busy,
  output logic                  done,
  output logic [FIELD_SIZE-1:0] sent
);

  localparam logic [LFSR_W-1:0] TAPS = LFSR_W'(LFSR_TAPS);

  gen_state_t            state;
  logic [LFSR_W-1:0]     lfsr;
  logic [LFSR_W-1:0]     lfsr_adv;
  logic [FIELD_SIZE-1:0] remaining;   // beats left, including the one presented
  logic [FIELD_SIZE-1:0] rep_left;    // repetitions still owed

  logic                  handshake;
  logic [FIELD_SIZE-1:0] slots_next;
  logic                  do_repeat;
  logic [FIELD_SIZE-1:0] fresh;
  logic [FIELD_SIZE-1:0] fresh_val;
  logic [FIELD_SIZE-1:0] len_m1;
  logic [FIELD_SIZE-1:0] eff_nreps;
  logic [LFSR_W-1:0]     seed_eff;

  lfsr_step #(
    .W (LFSR_W)
  ) u_step (
    .current  (lfsr),
    .taps     (TAPS),
    .advanced (lfsr_adv)
  );

  // The next beat is decided when the current one is accepted, and the result
  // is registered. A stall therefore holds field/clear and cannot change the
  // repeat/fresh decision.
  always_comb begin
    handshake  = valid && ready;
    slots_next = remaining - 1'b1;
    do_repeat  = (rep_left != '0) && (lfsr_adv[0] || (rep_left == slots_next));
    fresh      = lfsr_adv[FIELD_SIZE-1:0];
    fresh_val  = fresh;
    // A fresh value that matches the previous beat would count as an extra
    // repetition, so bit 0 is flipped to break the match.
    if (fresh == field) begin
      fresh_val[0] = ~fresh[0];
    end
  end

  always_comb begin
    len_m1   = cfg_len - 1'b1;
    seed_eff = (cfg_seed == '0) ? LFSR_W'(1) : cfg_seed;
    if (cfg_len <= FIELD_SIZE'(1)) begin
      eff_nreps = '0;
    end else if (cfg_nreps < len_m1) begin
      eff_nreps = cfg_nreps;
    end else begin
      eff_nreps = len_m1;
    end
  end

  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      lfsr      <= LFSR_W'(1);
      remaining <= '0;
      rep_left  <= '0;
      valid     <= 1'b0;
      field     <= '0;
      clear     <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      sent      <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          done <= 1'b0;
          if (start) begin
            sent      <= '0;
            lfsr      <= seed_eff;
            remaining <= cfg_len;
            rep_left  <= eff_nreps;
            if (cfg_len == '0) begin
              state <= ST_DONE;
              done  <= 1'b1;
            end else begin
              state <= ST_FIRST;
              valid <= 1'b1;
              clear <= 1'b1;
              busy  <= 1'b1;
              field <= seed_eff[FIELD_SIZE-1:0];
            end
          end
        end

        ST_FIRST, ST_RUN: begin
          if (handshake) begin
            sent  <= sent + 1'b1;
            lfsr  <= lfsr_adv;
            clear <= 1'b0;
            if (remaining == FIELD_SIZE'(1)) begin
              state <= ST_DONE;
              valid <= 1'b0;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              state     <= ST_RUN;
              remaining <= slots_next;
              if (do_repeat) begin
                rep_left <= rep_left - 1'b1;
              end else begin
                field <= fresh_val;
              end
            end
          end
        end

        ST_DONE: begin
          done  <= 1'b0;
          state <= ST_IDLE;
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_repetition_gen.sv
// Directed self-checking bench for repetition_gen with a beat scoreboard.
module tb_repetition_gen;

  logic        sys_clk;
  logic        reset;
  logic        start;
  logic [15:0] cfg_len;
  logic [15:0] cfg_nreps;
  logic [31:0] cfg_seed;
  logic        ready;
  logic        valid;
  logic [15:0] field;
  logic        clear;
  logic        busy;
  logic        done;
  logic [15:0] sent;

  repetition_gen #(
    .FIELD_SIZE (16),
    .LFSR_W     (32)
  ) dut (
    .sys_clk   (sys_clk),
    .reset     (reset),
    .start     (start),
    .cfg_len   (cfg_len),
    .cfg_nreps (cfg_nreps),
    .cfg_seed  (cfg_seed),
    .ready     (ready),
    .valid     (valid),
    .field     (field),
    .clear     (clear),
    .busy      (busy),
    .done      (done),
    .sent      (sent)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  typedef struct packed {
    logic [15:0] value;
    logic        clr;
  } beat_t;

  beat_t       exp_q[$];
  int unsigned tests  = 0;
  int unsigned failed = 0;
  int unsigned obs_reps;
  int unsigned beats_seen;
  bit          busy_seen;
  bit          stall_pending;
  logic [15:0] held_field;
  logic        held_clear;
  logic [15:0] prev_field;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic logic [31:0] model_step(input logic [31:0] s);
    logic [31:0] r;
    r = s >> 1;
    if (s[0]) r = r ^ 32'h8020_0003;
    return r;
  endfunction

  // Reference sequence for a window, as it would appear with ready held high.
  task automatic build_expected(input int unsigned len, input logic [31:0] seed,
                                input int unsigned eff);
    logic [31:0] s;
    logic [15:0] prev;
    logic [15:0] v;
    int unsigned rl;
    beat_t       b;
    exp_q.delete();
    if (len == 0) return;
    s    = (seed == 0) ? 32'd1 : seed;
    rl   = eff;
    prev = s[15:0];
    b.value = prev; b.clr = 1'b1;
    exp_q.push_back(b);
    for (int unsigned k = 1; k < len; k++) begin
      s = model_step(s);
      if (rl != 0 && (s[0] || rl == len - k)) begin
        v = prev;
        rl--;
      end else begin
        v = s[15:0];
        if (v == prev) v[0] = ~v[0];
      end
      b.value = v; b.clr = 1'b0;
      exp_q.push_back(b);
      prev = v;
    end
  endtask

  // Scoreboard monitor: a beat is taken at the negedge before the edge that accepts it.
  always @(negedge sys_clk) begin
    beat_t e;
    if (reset) begin
      stall_pending = 1'b0;
    end else begin
      if (busy) busy_seen = 1'b1;
      if (valid) begin
        if (stall_pending) begin
          check("stall_field", {16'd0, field}, {16'd0, held_field});
          check("stall_clear", {31'd0, clear}, {31'd0, held_clear});
        end
        if (ready) begin
          if (exp_q.size() == 0) begin
            check("unexpected_beat", 32'd1, 32'd0);
          end else begin
            e = exp_q.pop_front();
            check("field", {16'd0, field}, {16'd0, e.value});
            check("clear", {31'd0, clear}, {31'd0, e.clr});
          end
          if (!clear && field == prev_field) obs_reps++;
          prev_field    = field;
          beats_seen++;
          stall_pending = 1'b0;
        end else begin
          stall_pending = 1'b1;
          held_field    = field;
          held_clear    = clear;
        end
      end
    end
  end

  function automatic bit pat(input int i);
    return (i % 4 == 0) || (i % 4 == 3);
  endfunction

  task automatic run_window(input int unsigned len, input int unsigned nreps,
                            input logic [31:0] seed, input bit toggle, input bit poke);
    int unsigned eff;
    int unsigned lat;
    bit          finished;
    eff = (len <= 1) ? 0 : ((nreps < len - 1) ? nreps : len - 1);
    build_expected(len, seed, eff);
    obs_reps   = 0;
    beats_seen = 0;
    busy_seen  = 1'b0;
    cfg_len    = 16'(len);
    cfg_nreps  = 16'(nreps);
    cfg_seed   = seed;
    start      = 1'b1;
    @(posedge sys_clk); #1;
    start = 1'b0;
    check("start_valid", {31'd0, valid}, {31'd0, len != 0});
    check("start_busy",  {31'd0, busy},  {31'd0, len != 0});
    check("start_clear", {31'd0, clear}, {31'd0, len != 0});
    finished = 1'b0;
    lat      = 0;
    for (int i = 0; i < 300; i++) begin
      if (done) begin
        finished = 1'b1;
        lat      = i;
        break;
      end
      ready = toggle ? pat(i) : 1'b1;
      start = poke && (i == 2);
      if (poke && i == 2) begin
        cfg_len   = 16'd3;
        cfg_nreps = 16'd0;
        cfg_seed  = 32'h5;
      end
      @(posedge sys_clk); #1;
    end
    start = 1'b0;
    check("done_timeout", {31'd0, finished}, 32'd1);
    if (!toggle) check("done_latency", lat, len);
    check("busy_at_done", {31'd0, busy}, 32'd0);
    check("sent", {16'd0, sent}, len);
    check("beats", beats_seen, len);
    check("reps", obs_reps, eff);
    check("queue_empty", exp_q.size(), 32'd0);
    if (len == 0) check("busy_never", {31'd0, busy_seen}, 32'd0);
    @(posedge sys_clk); #1;
    check("done_pulse", {31'd0, done}, 32'd0);
  endtask

  initial begin
    reset         = 1'b1;
    start         = 1'b0;
    cfg_len       = '0;
    cfg_nreps     = '0;
    cfg_seed      = '0;
    ready         = 1'b0;
    stall_pending = 1'b0;
    prev_field    = '0;
    held_field    = '0;
    held_clear    = 1'b0;
    repeat (3) @(posedge sys_clk);
    #1;
    check("rst_valid", {31'd0, valid}, 32'd0);
    check("rst_clear", {31'd0, clear}, 32'd0);
    check("rst_field", {16'd0, field}, 32'd0);
    check("rst_busy",  {31'd0, busy},  32'd0);
    check("rst_done",  {31'd0, done},  32'd0);
    check("rst_sent",  {16'd0, sent},  32'd0);
    reset = 1'b0;
    @(posedge sys_clk); #1;

    run_window(10, 3, 32'h0000_ACE1, 1'b0, 1'b0);
    run_window(8, 20, 32'h0000_ACE1, 1'b0, 1'b0);
    run_window(5, 0, 32'h0, 1'b0, 1'b0);
    run_window(6, 2, 32'h0000_BEEF, 1'b0, 1'b0);
    run_window(6, 2, 32'h0000_BEEF, 1'b1, 1'b0);
    run_window(0, 4, 32'h1234, 1'b0, 1'b0);
    run_window(1, 4, 32'h1234, 1'b0, 1'b0);
    run_window(12, 5, 32'hDEAD_0001, 1'b1, 1'b0);

    // Reset while beat 3 of a 10-beat window is presented.
    build_expected(10, 32'h0000_1234, 3);
    cfg_len   = 16'd10;
    cfg_nreps = 16'd3;
    cfg_seed  = 32'h0000_1234;
    start     = 1'b1;
    @(posedge sys_clk); #1;
    start = 1'b0;
    ready = 1'b1;
    repeat (3) @(posedge sys_clk);
    #1;
    check("pre_rst_sent", {16'd0, sent}, 32'd3);
    reset = 1'b1;
    #1;
    check("mid_rst_valid", {31'd0, valid}, 32'd0);
    check("mid_rst_clear", {31'd0, clear}, 32'd0);
    check("mid_rst_field", {16'd0, field}, 32'd0);
    check("mid_rst_busy",  {31'd0, busy},  32'd0);
    check("mid_rst_sent",  {16'd0, sent},  32'd0);
    exp_q.delete();
    @(posedge sys_clk); #1;
    reset = 1'b0;
    check("mid_rst_done", {31'd0, done}, 32'd0);
    @(posedge sys_clk); #1;
    check("post_rst_done", {31'd0, done}, 32'd0);

    // Fresh window after reset; a start pulse mid-window must be ignored.
    run_window(6, 2, 32'h0000_0777, 1'b0, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
